// File: rtl/dword_split_seq.sv
// -----------------------------------------------------------------------------
// dword_split_seq
//
// Purpose:
//   Splits 32-bit dwords arriving on a valid/ready input into two 16-bit beats
//   on a valid/ready output. It time-multiplexes a single 16-bit output path
//   and sustains one dword every two cycles when the consumer never stalls.
//   The dword and word widths match definitions::dword_t (32 bits) and
//   definitions::word_t (16 bits).
//
//   Default beat order: the low half hold[15:0] (instruction, out_is_abs=0)
//   goes first, then the high half hold[31:16] (absolute, out_is_abs=1).
//
// Configuration macro:
//   DWORD_SPLIT_HI_FIRST_EN - when defined, the beat order is reversed: the
//     high half goes first (out_is_abs=1), then the low half (out_is_abs=0).
//     out_last still marks the second beat of each dword.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
//   valid and ready are both high. Once out_valid is high it stays high, with
//   out_word/out_is_abs/out_last stable, until that transfer happens. in_dword
//   is sampled only on an input transfer.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high
//   in_valid     in   source has a dword
//   in_dword     in   [31:0] source data
//   in_ready     out  dword accepted this cycle (forced 0 during reset)
//   out_valid    out  out_word is valid (registered)
//   out_word     out  [15:0] current half (registered)
//   out_is_abs   out  0 = bits 15:0, 1 = bits 31:16 (registered)
//   out_last     out  final beat of a dword (registered)
//   out_ready    in   consumer takes out_word this cycle
//   dword_count  out  [CNT_W-1:0] dwords fully emitted, wraps silently
//   fsm_state    out  [1:0] debug view of the FSM: 0 = IDLE, 1 = LOW
//                     (first beat presented), 2 = HIGH (second beat presented)
//
// Parameters:
//   CNT_W        width of the completed-dword counter (default 16)
// -----------------------------------------------------------------------------
module dword_split_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_dword,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_word,
  output logic             out_is_abs,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] dword_count,
  output logic [1:0]       fsm_state
);

  // LOW presents the first beat of the held dword and HIGH the second one.
  // In the default build that is literally the low then the high half; with
  // the reversed-order build the names keep their first/second meaning.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

`ifdef DWORD_SPLIT_HI_FIRST_EN
  localparam logic FIRST_IS_ABS = 1'b1;
`else
  localparam logic FIRST_IS_ABS = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] hold;

  // Half of a dword that is presented as the first beat.
  function automatic logic [15:0] first_half(input logic [31:0] d);
    return FIRST_IS_ABS ? d[31:16] : d[15:0];
  endfunction

  // Half of a dword that is presented as the second (last) beat.
  function automatic logic [15:0] second_half(input logic [31:0] d);
    return FIRST_IS_ABS ? d[15:0] : d[31:16];
  endfunction

  // The only combinational path through the block: in HIGH a new dword can
  // be taken in the same cycle the second beat leaves, so the output path
  // never bubbles.
  assign in_ready = !reset &&
                    ((state == IDLE) || ((state == HIGH) && out_ready));

  assign fsm_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      dword_count <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_is_abs  <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // out_word is loaded straight from the accepted dword so the
            // first beat is registered and valid in the very next cycle.
            hold       <= in_dword;
            out_valid  <= 1'b1;
            out_word   <= first_half(in_dword);
            out_is_abs <= FIRST_IS_ABS;
            out_last   <= 1'b0;
            state      <= LOW;
          end
        end

        LOW: begin
          // Without out_ready everything simply holds its value.
          if (out_ready) begin
            out_word   <= second_half(hold);
            out_is_abs <= !FIRST_IS_ABS;
            out_last   <= 1'b1;
            state      <= HIGH;
          end
        end

        HIGH: begin
          if (out_ready) begin
            dword_count <= dword_count + CNT_ONE;
            if (in_valid) begin
              // Back-to-back: next dword's first beat follows immediately.
              hold       <= in_dword;
              out_valid  <= 1'b1;
              out_word   <= first_half(in_dword);
              out_is_abs <= FIRST_IS_ABS;
              out_last   <= 1'b0;
              state      <= LOW;
            end else begin
              // out_word/out_is_abs keep their last value; only out_valid
              // and out_last drop so no stale "last" flag lingers.
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        default: begin
          // Unreachable encoding: recover to an empty pipeline.
          out_valid  <= 1'b0;
          out_last   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dword_split_seq.md
# dword_split_seq

Sequencer that takes 32-bit `dword_t` words on a valid/ready input and presents them as two 16-bit `word_t` beats on a valid/ready output. The low half (bits 15:0, instruction) is sent first, then the high half (bits 31:16, absolute). It sits between a 32-bit fetch/memory source and 16-bit consumers of the `definitions` package types. It time-multiplexes one 16-bit output path and sustains one dword every two cycles.

## Interface
Parameters:
- `CNT_W`, default 16: width of the completed-dword counter.

Ports:
- `clock`: input, 1 bit. Single clock; all state changes on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `in_valid`: input, 1 bit. Source has a dword.
- `in_dword`: input, `dword_t` (32 bits). Source data.
- `in_ready`: output, 1 bit. Block accepts `in_dword` this cycle.
- `out_valid`: output, 1 bit. `out_word` is valid.
- `out_word`: output, `word_t` (16 bits). Current half.
- `out_is_abs`: output, 1 bit. 0 = instruction half (bits 15:0); 1 = absolute half (bits 31:16).
- `out_last`: output, 1 bit. Same as `out_is_abs`; marks the final beat of a dword.
- `out_ready`: input, 1 bit. Consumer takes `out_word` this cycle.
- `dword_count`: output, `CNT_W` bits. Number of dwords fully emitted; wraps modulo 2^CNT_W.

## Operation
- Internal 32-bit holding register `hold`. FSM states: IDLE, LOW, HIGH.
- **IDLE:**
  - `out_valid`=0, `in_ready`=1.
  - On `in_valid`: load `hold`=`in_dword` and go to LOW.
- **LOW:**
  - `out_valid`=1, `out_word`=`hold[15:0]`, `out_is_abs`=0, `in_ready`=0.
  - On `out_ready`: go to HIGH.
  - Without `out_ready`: stay; `out_word` stays stable.
- **HIGH:**
  - `out_valid`=1, `out_word`=`hold[31:16]`, `out_is_abs`=1.
  - `in_ready`=`out_ready` (combinational pass-through).
  - On `out_ready`:
    - `dword_count` increments.
    - If `in_valid`: load `hold`=`in_dword` and go to LOW (back-to-back, no bubble).
    - Else: go to IDLE.
- Once `out_valid` is high, it never drops before its handshake (`out_ready`).
- `in_dword` is sampled only on an input handshake; other changes to it are ignored.
- `dword_count` wraps from 2^CNT_W−1 to 0 without any flag.

## Timing
- Reset values:
  - State IDLE, `hold`=0, `dword_count`=0.
  - `out_valid`=0, `out_word`=0, `out_is_abs`=0, `out_last`=0.
  - `in_ready` is forced to 0 while `reset` is high.
- Latency: dword accepted at edge N → low half valid in cycle N+1, high half in the cycle after the low-half handshake.
- Throughput: with `out_ready` held at 1, one dword per 2 cycles and `out_valid` continuously high.
- Reset mid-dword: the pending beat is dropped, the FSM returns to IDLE, and no count increment occurs.
- Reset asserted in the same cycle as an input handshake: reset wins and the dword is discarded.
- Combinational paths: only `out_ready`→`in_ready`. `out_*` are registered/state-decoded, with no path from `in_*` to `out_*` in the same cycle.

## Configuration
- Macro `DWORD_SPLIT_HI_FIRST_EN`.
- Defined:
  - Beat order is reversed: `hold[31:16]` first with `out_is_abs`=1, then `hold[15:0]` with `out_is_abs`=0.
  - `out_last` marks the second beat, so `out_last` = !`out_is_abs`.
- Undefined: low-first order exactly as in Operation.

## Test plan
- **Reset:** hold `reset`=1 for 3 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0, `dword_count`=0 throughout.
- **Single dword:** send 32'h00BABACA, `out_ready`=1 → beats 16'hBACA (`out_is_abs`=0), then 16'h00BA (`out_is_abs`=1, `out_last`=1); `dword_count`=1; FSM back in IDLE.
- **Back-to-back:** stream 32'h11112222, 32'h33334444, 32'h55556666 with `out_ready`=1 → `out_word` = 2222, 1111, 4444, 3333, 6666, 5555 on consecutive cycles; `dword_count`=3.
- **Backpressure:** `out_ready`=0 for 4 cycles during LOW of 32'hDEADBEEF → `out_word` stays BEEF; `in_ready`=0; `in_dword` changes are ignored; output resumes with BEEF then DEAD.
- **Wrap and reset:** with `CNT_W`=2, send 5 dwords → `dword_count` = 1, 2, 3, 0, 1. Then assert reset while in HIGH → `out_valid`=0 next cycle and the count clears to 0.
- **Macro build:** compile with `DWORD_SPLIT_HI_FIRST_EN` and send 32'h00BABACA → 00BA then BACA; `out_last`=1 on BACA.
